// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Program loader placed in front of program memory. While load_req is high
// the CPU is held and a framed byte stream is received over a valid/ready
// link:  ADDR word, LEN word (N), N data words, CSUM word.  Words are
// assembled big-endian from DATA_W/8 bytes. Each data word is written to
// (base + i) mod 2^ADDR_W with a one-cycle write strobe. The CSUM word is
// compared against the running sum of ADDR + LEN + data words.
// When idle, the CPU program counter is passed straight to mem_addr.
//
// Ports:
//   clk       - single clock, all state changes on the rising edge
//   reset     - asynchronous, active-low reset
//   load_req  - level-sensitive load request
//   pc        - CPU program counter (forwarded when idle)
//   rx_data   - incoming byte
//   rx_valid  - rx_data is valid
//   rx_ready  - loader accepts a byte this cycle
//   mem_addr  - program memory address
//   mem_wdata - program memory write data
//   mem_we    - one-cycle write strobe
//   cpu_hold  - CPU must stall
//   done      - frame loaded, checksum good
//   err       - frame loaded, checksum bad
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;

  logic                receiving;
  logic                byte_fire;
  logic                word_done;
  logic [DATA_W-1:0]   word_full;

  assign receiving = (state_q == HDR_ADDR) || (state_q == HDR_LEN) ||
                     (state_q == DATA)     || (state_q == CSUM);

  assign rx_ready  = receiving;
  assign cpu_hold  = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = (state_q == IDLE) ? pc : addr_q;

  // The word as it will look once the current byte is shifted in; it is the
  // complete big-endian word whenever this byte is the last of the word.
  assign byte_fire = rx_valid && rx_ready;
  assign word_full = (word_q << 8) | DATA_W'(rx_data);
  assign word_done = byte_fire && (byte_cnt_q == LAST_BYTE);

  // Next-state, byte assembly and write generation.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;

    if (byte_fire) begin
      if (word_done) begin
        byte_cnt_d = '0;
        word_d     = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        word_d     = word_full;
      end
    end

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        word_d     = '0;
        if (load_req) state_d = HDR_ADDR;
      end
      HDR_ADDR: begin
        if (word_done) begin
          next_addr_d = word_full[ADDR_W-1:0];
          idx_d       = '0;
          sum_d       = word_full;
          state_d     = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (word_done) begin
          len_d   = word_full;
          sum_d   = sum_q + word_full;
          state_d = (word_full != '0) ? DATA : CSUM;
        end
      end
      DATA: begin
        if (word_done) begin
          addr_d      = next_addr_q;
          wdata_d     = word_full;
          we_d        = 1'b1;
          next_addr_d = next_addr_q + ADDR_W'(1);
          sum_d       = sum_q + word_full;
          idx_d       = idx_q + DATA_W'(1);
          if (idx_q == len_q - DATA_W'(1)) state_d = CSUM;
        end
      end
      CSUM: begin
        if (word_done) state_d = (word_full == sum_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (!load_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping load_req mid-frame discards the partial word; a word that
    // completes in the abort cycle is discarded too so that no strobe can
    // appear while mem_addr is already back on the pc.
    if (receiving && !load_req) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      word_d     = '0;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      next_addr_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

endmodule
